// File: rtl/regbank_pkg.sv
// Shared types and sizes for the one-hot register bank.
// Entry count is tied to the 3-to-8 decoder that drives wr_sel.
package regbank_pkg;

  localparam int NUM_ENTRIES = 8;
  localparam int ADDR_W      = 3;

  typedef enum logic {
    SWEEP,
    IDLE
  } bank_state_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_ONE,
    SEL_MULTI
  } sel_class_t;

endpackage

// File: rtl/onehot_check.sv
// Classifies a write select as empty, one-hot or multi-hot.
// Purely combinational; x & (x-1) drops the lowest set bit.
module onehot_check
  import regbank_pkg::*;
(
  input  logic [NUM_ENTRIES-1:0] sel_i,
  output sel_class_t             cls_o
);

  logic [NUM_ENTRIES-1:0] low_drop;
  logic                   is_zero;
  logic                   is_one;

  assign low_drop = sel_i & (sel_i - NUM_ENTRIES'(1));
  assign is_zero  = (sel_i == '0);
  assign is_one   = !is_zero && (low_drop == '0);

  always_comb begin
    cls_o = SEL_MULTI;
    unique case (1'b1)
      is_zero: cls_o = SEL_NONE;
      is_one:  cls_o = SEL_ONE;
      default: cls_o = SEL_MULTI;
    endcase
  end

endmodule

// File: rtl/onehot_reg_bank.sv
// 8-entry register bank with one-hot writes, a clear sweep and a registered read port.
// Define REGBANK_FWD_EN for write-first same-entry reads; default is read-first.
module onehot_reg_bank
  import regbank_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_ENTRIES-1:0] wr_sel,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic                   clr_req,
  input  logic                   rd_en,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  output logic                   busy,
  output logic                   sel_err
);

  bank_state_t       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] sweep_idx;
  logic              sweep_clr;
  logic              sweep_start;

  logic              sel_err_q, sel_err_d;
  logic [WIDTH-1:0]  rd_data_q, rd_data_d;
  logic              rd_valid_q;
  logic              rd_fwd;

  logic [WIDTH-1:0]  mem_q [NUM_ENTRIES];

  sel_class_t        sel_cls;
  logic              wr_fire;
  logic              wr_one;
  logic              wr_multi;

  onehot_check u_check (
    .sel_i (wr_sel),
    .cls_o (sel_cls)
  );

  assign wr_ready = (state_q == IDLE);
  assign busy     = (state_q == SWEEP);
  assign wr_fire  = wr_valid && wr_ready;
  assign wr_one   = wr_fire && (sel_cls == SEL_ONE);
  assign wr_multi = wr_fire && (sel_cls == SEL_MULTI);

  // A clr_req mid-sweep rewinds so this very cycle clears entry 0.
  assign sweep_idx = clr_req ? '0 : ptr_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sweep_clr   = 1'b0;
    sweep_start = 1'b0;
    unique case (state_q)
      SWEEP: begin
        sweep_clr   = 1'b1;
        sweep_start = clr_req;
        ptr_d       = sweep_idx + ADDR_W'(1);
        if (sweep_idx == ADDR_W'(NUM_ENTRIES - 1)) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (clr_req) begin
          state_d     = SWEEP;
          ptr_d       = '0;
          sweep_start = 1'b1;
        end
      end
      default: state_d = SWEEP;
    endcase
  end

  always_comb begin
    sel_err_d = sel_err_q;
    if (sweep_start) begin
      sel_err_d = 1'b0;
    end else if (wr_multi) begin
      sel_err_d = 1'b1;
    end
  end

`ifdef REGBANK_FWD_EN
  assign rd_fwd = wr_one && wr_sel[rd_addr];
`else
  assign rd_fwd = 1'b0;
`endif

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = rd_fwd ? wr_data : mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SWEEP;
      ptr_q      <= '0;
      sel_err_q  <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_err_q  <= sel_err_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en;
    end
  end

  // Storage has no reset; the post-reset sweep zeroes it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (sweep_clr && (sweep_idx == ADDR_W'(i))) begin
        mem_q[i] <= '0;
      end else if (wr_one && wr_sel[i]) begin
        mem_q[i] <= wr_data;
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign sel_err  = sel_err_q;

endmodule

// File: tb/tb_onehot_reg_bank.sv
// Self-checking bench for onehot_reg_bank.
// Reference model: plain array of entries plus a sweep countdown.
module tb_onehot_reg_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  wr_sel;
  logic [63:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic        clr_req;
  logic        rd_en;
  logic [2:0]  rd_addr;
  logic [63:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic        sel_err;

  int total = 0;
  int bad   = 0;

  logic [63:0] mdl [8];
  logic        mdl_err;

`ifdef REGBANK_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  always #5 clk = ~clk;

  onehot_reg_bank #(.WIDTH(64)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_sel   (wr_sel),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .clr_req  (clr_req),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .busy     (busy),
    .sel_err  (sel_err)
  );

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic quiet();
    wr_sel   = '0;
    wr_data  = '0;
    wr_valid = 1'b0;
    clr_req  = 1'b0;
    rd_en    = 1'b0;
    rd_addr  = '0;
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    mdl_err = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    mdl_clear();
    total++;
    if (rd_valid !== 1'b0 || rd_data !== 64'h0 || sel_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_out: rd_valid=%b rd_data=%h sel_err=%b want 0/0/0",
               rd_valid, rd_data, sel_err);
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (busy !== 1'b1 || wr_ready !== 1'b0) begin
        bad++;
        $display("FAIL reset_sweep[%0d]: busy=%b wr_ready=%b want 1/0",
                 i, busy, wr_ready);
      end
      cyc();
    end
    total++;
    if (busy !== 1'b0 || wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_idle: busy=%b wr_ready=%b want 0/1", busy, wr_ready);
    end
    for (int i = 0; i < 8; i++) begin
      rd_en   = 1'b1;
      rd_addr = 3'(i);
      cyc();
      total++;
      if (rd_valid !== 1'b1 || rd_data !== 64'h0) begin
        bad++;
        $display("FAIL reset_read[%0d]: rd_valid=%b rd_data=%h want 1/0",
                 i, rd_valid, rd_data);
      end
    end
    rd_en = 1'b0;
    cyc();
    total++;
    if (rd_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_rdv_drop: rd_valid=%b want 0", rd_valid);
    end
  endtask

  task automatic test_write();
    wr_sel   = 8'b0000_0100;
    wr_data  = 64'hDEAD_BEEF;
    wr_valid = 1'b1;
    cyc();
    wr_valid = 1'b0;
    mdl[2]   = 64'hDEAD_BEEF;
    rd_en    = 1'b1;
    rd_addr  = 3'd2;
    cyc();
    rd_en = 1'b0;
    total++;
    if (rd_valid !== 1'b1 || rd_data !== 64'hDEAD_BEEF) begin
      bad++;
      $display("FAIL write_read: rd_valid=%b rd_data=%h want 1/deadbeef",
               rd_valid, rd_data);
    end
    cyc();
    total++;
    if (rd_valid !== 1'b0 || rd_data !== 64'hDEAD_BEEF) begin
      bad++;
      $display("FAIL write_hold: rd_valid=%b rd_data=%h want 0/deadbeef",
               rd_valid, rd_data);
    end
  endtask

  task automatic test_multi();
    logic [63:0] exp;
    int n;
    wr_valid = 1'b1;
    wr_sel   = 8'b0000_0010;
    wr_data  = 64'h11;
    cyc();
    wr_sel   = 8'b0001_0000;
    wr_data  = 64'h44;
    cyc();
    mdl[1] = 64'h11;
    mdl[4] = 64'h44;
    wr_sel  = 8'b0001_0010;
    wr_data = 64'hFFFF;
    cyc();
    wr_valid = 1'b0;
    mdl_err  = 1'b1;
    total++;
    if (sel_err !== 1'b1) begin
      bad++;
      $display("FAIL multi_err: sel_err=%b want 1", sel_err);
    end
    for (int k = 0; k < 2; k++) begin
      rd_en   = 1'b1;
      rd_addr = (k == 0) ? 3'd1 : 3'd4;
      exp     = mdl[rd_addr];
      cyc();
      total++;
      if (rd_data !== exp || sel_err !== 1'b1) begin
        bad++;
        $display("FAIL multi_nowrite[%0d]: rd_data=%h sel_err=%b want %h/1",
                 rd_addr, rd_data, sel_err, exp);
      end
    end
    rd_en   = 1'b0;
    clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    mdl_clear();
    total++;
    if (sel_err !== 1'b0) begin
      bad++;
      $display("FAIL clr_err: sel_err=%b want 0", sel_err);
    end
    n = 0;
    while (busy === 1'b1 && n < 30) begin
      cyc();
      n++;
    end
    total++;
    if (n != 8) begin
      bad++;
      $display("FAIL clr_busy_len: cycles=%0d want 8", n);
    end
    rd_en   = 1'b1;
    rd_addr = 3'd4;
    cyc();
    rd_en = 1'b0;
    total++;
    if (rd_data !== 64'h0) begin
      bad++;
      $display("FAIL clr_cleared: rd_data=%h want 0", rd_data);
    end
  endtask

  task automatic test_zero();
    wr_sel   = 8'h00;
    wr_data  = 64'hABC;
    wr_valid = 1'b1;
    cyc();
    wr_valid = 1'b0;
    total++;
    if (sel_err !== 1'b0) begin
      bad++;
      $display("FAIL zero_err: sel_err=%b want 0", sel_err);
    end
    for (int i = 0; i < 8; i++) begin
      rd_en   = 1'b1;
      rd_addr = 3'(i);
      cyc();
      total++;
      if (rd_data !== mdl[i]) begin
        bad++;
        $display("FAIL zero_nowrite[%0d]: rd_data=%h want %h", i, rd_data, mdl[i]);
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_same_cycle();
    logic [63:0] exp;
    exp      = FWD ? 64'h55 : mdl[5];
    wr_sel   = 8'b0010_0000;
    wr_data  = 64'h55;
    wr_valid = 1'b1;
    rd_en    = 1'b1;
    rd_addr  = 3'd5;
    cyc();
    wr_valid = 1'b0;
    mdl[5]   = 64'h55;
    total++;
    if (rd_valid !== 1'b1 || rd_data !== exp) begin
      bad++;
      $display("FAIL same_cycle: rd_data=%h want %h", rd_data, exp);
    end
    cyc();
    rd_en = 1'b0;
    total++;
    if (rd_data !== 64'h55) begin
      bad++;
      $display("FAIL same_after: rd_data=%h want 55", rd_data);
    end
  endtask

  task automatic test_random();
    int          cnt = 0;
    logic        pend = 1'b0;
    logic [63:0] pend_exp = '0;
    logic        one;
    int          pick;
    cyc();
    for (int it = 0; it < 400; it++) begin
      total++;
      if (rd_valid !== pend || (pend && rd_data !== pend_exp)) begin
        bad++;
        $display("FAIL rand_read@%0d: rd_valid=%b rd_data=%h want %b/%h",
                 it, rd_valid, rd_data, pend, pend_exp);
      end
      total++;
      if (sel_err !== mdl_err || wr_ready !== (cnt == 0)) begin
        bad++;
        $display("FAIL rand_state@%0d: sel_err=%b wr_ready=%b want %b/%b",
                 it, sel_err, wr_ready, mdl_err, cnt == 0);
      end
      pick     = int'($urandom_range(0, 9));
      wr_valid = ($urandom_range(0, 9) < 7);
      wr_data  = {$urandom, $urandom};
      if (pick < 8) begin
        wr_sel = 8'(1 << $urandom_range(0, 7));
      end else if (pick == 8) begin
        wr_sel = 8'h00;
      end else begin
        wr_sel = 8'($urandom);
        if ($countones(wr_sel) < 2) wr_sel = 8'h81;
      end
      one     = ($countones(wr_sel) == 1);
      rd_addr = 3'($urandom_range(0, 7));
      if (cnt > 0) begin
        clr_req = 1'b0;
        rd_en   = 1'b0;
        pend    = 1'b0;
        cnt--;
      end else begin
        clr_req = ($urandom_range(0, 29) == 0);
        rd_en   = $urandom_range(0, 1) == 1;
        pend    = rd_en;
        if (FWD && wr_valid && one && wr_sel[rd_addr]) pend_exp = wr_data;
        else if (rd_en) pend_exp = mdl[rd_addr];
        if (wr_valid && one) begin
          for (int i = 0; i < 8; i++) if (wr_sel[i]) mdl[i] = wr_data;
        end
        if (wr_valid && $countones(wr_sel) > 1) mdl_err = 1'b1;
        if (clr_req) begin
          mdl_clear();
          cnt = 8;
        end
      end
      cyc();
    end
    quiet();
    total++;
    if (rd_valid !== pend || (pend && rd_data !== pend_exp)) begin
      bad++;
      $display("FAIL rand_last: rd_data=%h want %h", rd_data, pend_exp);
    end
    while (busy === 1'b1 && cnt > 0) begin
      cyc();
      cnt--;
    end
  endtask

  task automatic test_restart();
    int n;
    clr_req = 1'b1;
    cyc();
    mdl_clear();
    n = 0;
    while (busy === 1'b1 && n < 30) begin
      clr_req = (n == 4);
      cyc();
      clr_req = 1'b0;
      n++;
    end
    total++;
    if (n != 12) begin
      bad++;
      $display("FAIL restart_len: busy cycles=%0d want 12", n);
    end
    wr_sel   = 8'b1000_0000;
    wr_data  = 64'h77;
    wr_valid = 1'b1;
    rd_en    = 1'b1;
    rd_addr  = 3'd7;
    cyc();
    wr_valid = 1'b0;
    rd_en    = 1'b0;
    clr_req  = 1'b1;
    cyc();
    clr_req = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    total++;
    if (busy !== 1'b1 || sel_err !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 64'h0) begin
      bad++;
      $display("FAIL midreset: busy=%b sel_err=%b rd_valid=%b rd_data=%h want 1/0/0/0",
               busy, sel_err, rd_valid, rd_data);
    end
    n = 0;
    while (busy === 1'b1 && n < 30) begin
      cyc();
      n++;
    end
    total++;
    if (n != 8) begin
      bad++;
      $display("FAIL midreset_len: busy cycles=%0d want 8", n);
    end
    rd_en   = 1'b1;
    rd_addr = 3'd7;
    cyc();
    rd_en = 1'b0;
    total++;
    if (rd_data !== 64'h0) begin
      bad++;
      $display("FAIL midreset_clear: rd_data=%h want 0", rd_data);
    end
  endtask

  initial begin
    reset = 1'b1;
    quiet();
    @(negedge clk);
    test_reset();
    test_write();
    test_multi();
    test_zero();
    test_same_cycle();
    test_random();
    test_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
